// File: rtl/itcm_arb_pkg.sv
// ============================================================================
// Module      : itcm_arb_pkg
// Description : Shared definitions for the ITCM arbiter: default SRAM geometry
//               and the two-way round-robin grant function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// Fallback SRAM geometry, used when defines.v has not already provided it.
`ifndef ITCM_RAM_AW
`define ITCM_RAM_AW 16
`endif
`ifndef ITCM_RAM_DW
`define ITCM_RAM_DW 32
`endif
`ifndef ITCM_RAM_MW
`define ITCM_RAM_MW 4
`endif

package itcm_arb_pkg;

    // Requester bit positions inside a two-bit request/grant vector.
    localparam int unsigned c_REQ_IFU = 0;
    localparam int unsigned c_REQ_LSU = 1;

    // Two-way round-robin pick. last_lsu = 1 means the LSU won the previous
    // arbitration, so the IFU wins a tie now (and vice versa).
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_lsu);
        logic [1:0] gnt;
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_lsu ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        return gnt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/itcm_arb_rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter with its last-grant pointer.
//               Bit 0 is the IFU, bit 1 the LSU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
    import itcm_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt
);

    // 1 = LSU won last; reset to IFU so the LSU wins the first tie.
    logic r_last_lsu;

    // Pointer only moves when a grant is actually taken by its requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_lsu <= 1'b0;
        end else if (upd) begin
            r_last_lsu <= gnt[c_REQ_LSU];
        end
    end

    // Grant is purely a function of current requests and the pointer.
    always_comb begin
        gnt = rr_pick(req, r_last_lsu);
    end

endmodule

`default_nettype wire

// File: rtl/itcm_arb.sv
// ============================================================================
// Module      : itcm_arb
// Description : Arbitrates the IFU (read-only) and LSU ports onto a single
//               ITCM SRAM port, one access per cycle, response owed to the
//               accepted requester in the following cycle(s).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module itcm_arb
    import itcm_arb_pkg::*;
#(
    parameter int AW = `ITCM_RAM_AW,
    parameter int DW = `ITCM_RAM_DW,
    parameter int MW = `ITCM_RAM_MW
) (
    input  logic          clk,
    input  logic          rst,
    // IFU request / response
    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [AW-1:0] ifu_req_addr,
    output logic          ifu_rsp_valid,
    input  logic          ifu_rsp_ready,
    output logic [DW-1:0] ifu_rsp_rdata,
    // LSU request / response
    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic          lsu_req_we,
    input  logic [AW-1:0] lsu_req_addr,
    input  logic [DW-1:0] lsu_req_wdata,
    input  logic [MW-1:0] lsu_req_wem,
    output logic          lsu_rsp_valid,
    input  logic          lsu_rsp_ready,
    output logic [DW-1:0] lsu_rsp_rdata,
    // SRAM port
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic [MW-1:0] ram_wem,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RESP = 1'b1;
    localparam logic [0:0] c_OWN_IFU = 1'b0;
    localparam logic [0:0] c_OWN_LSU = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic [0:0]    r_owner;
    logic          r_owner_is_write;
    logic [DW-1:0] r_hold;
    logic          r_held;

    logic          w_owner_rsp_ready;
    logic          w_can_issue;
    logic [1:0]    w_gnt;
    logic          w_acc_ifu;
    logic          w_acc_lsu;
    logic          w_acc;
    logic [DW-1:0] w_rsp_data;

    // Handshake view of the outstanding response and the issue window.
    always_comb begin
        w_owner_rsp_ready = (r_owner == c_OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready;
        w_can_issue       = (r_state == c_ST_IDLE) ||
                            ((r_state == c_ST_RESP) && w_owner_rsp_ready);
        ifu_req_ready     = w_can_issue && w_gnt[c_REQ_IFU];
        lsu_req_ready     = w_can_issue && w_gnt[c_REQ_LSU];
        w_acc_ifu         = ifu_req_valid && ifu_req_ready;
        w_acc_lsu         = lsu_req_valid && lsu_req_ready;
        w_acc             = w_acc_ifu || w_acc_lsu;
        // SRAM data is only valid in the first response cycle; afterwards
        // the captured copy is replayed until the owner takes it.
        if (r_held) begin
            w_rsp_data = r_hold;
        end else if (r_owner_is_write) begin
            w_rsp_data = '0;
        end else begin
            w_rsp_data = ram_dout;
        end
    end

    rr_arb2 u_rr_arb2 (
        .clk (clk),
        .rst (rst),
        .req ({lsu_req_valid, ifu_req_valid}),
        .upd (w_acc),
        .gnt (w_gnt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a new acceptance always lands in RESP (back-to-back).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_acc) begin
                    w_state_nxt = c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                if (w_acc) begin
                    w_state_nxt = c_ST_RESP;
                end else if (w_owner_rsp_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Outputs: response toward the owner only, SRAM port only on acceptance.
    always_comb begin
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        ifu_rsp_rdata = '0;
        lsu_rsp_rdata = '0;
        ram_we        = 1'b0;
        ram_addr      = '0;
        ram_din       = '0;
        ram_wem       = '0;
        if (r_state == c_ST_RESP) begin
            if (r_owner == c_OWN_LSU) begin
                lsu_rsp_valid = 1'b1;
                lsu_rsp_rdata = w_rsp_data;
            end else begin
                ifu_rsp_valid = 1'b1;
                ifu_rsp_rdata = w_rsp_data;
            end
        end
        if (w_acc_lsu) begin
            ram_we   = lsu_req_we;
            ram_addr = lsu_req_addr;
            ram_din  = lsu_req_wdata;
            ram_wem  = lsu_req_wem;
        end else if (w_acc_ifu) begin
            ram_addr = ifu_req_addr;
        end
    end

    // Owner bookkeeping and the stalled-response hold register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner          <= c_OWN_IFU;
            r_owner_is_write <= 1'b0;
            r_hold           <= '0;
            r_held           <= 1'b0;
        end else if (w_acc) begin
            r_owner          <= w_acc_lsu ? c_OWN_LSU : c_OWN_IFU;
            r_owner_is_write <= w_acc_lsu && lsu_req_we;
            r_held           <= 1'b0;
        end else if ((r_state == c_ST_RESP) && !w_owner_rsp_ready && !r_held) begin
            r_hold           <= w_rsp_data;
            r_held           <= 1'b1;
        end
    end

endmodule

`default_nettype wire
